// File: rtl/bbc_host_cycle_ctrl.sv
// Host-bus cycle sequencer: aligns CPU accesses to host phi0 (or the 1MHz slot),
// stretches the CPU meanwhile and keeps shadow copies of ROM-select/shadow-RAM regs.
module bbc_host_cycle_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned TIMEOUT     = 63
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       bbc_phi0,
    input  logic [1:0] j,
    input  logic       host_req,
    input  logic       cpu_rnw,
    input  logic [7:0] cpu_data,
    input  logic       dec_rom_reg,
    input  logic       dec_shadow_reg,
    input  logic       dec_fe4x,
    output logic       lat_en,
    output logic       cpu_rdy,
    output logic       host_busy,
    output logic       timeout_err,
    output logic [3:0] rom_bank_q,
    output logic       shadow_en_q
);

    localparam int unsigned WAIT_W = 6;
    localparam int unsigned HOLD_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [1:0]        J_BPLUS   = 2'b01;
    localparam logic [1:0]        J_ELK     = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_HOLD, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [SYNC_STAGES-1:0]  phi0_sync;
    logic                    phi0_d;
    logic                    slot1m_q;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [HOLD_W-1:0]       hold_cnt;

    logic                    req_rnw, req_rom, req_shd, req_fe4x, req_abort;
    logic [1:0]              req_j;
    logic [3:0]              req_lo;
    logic                    req_b7;

    logic phi0_rise_c, edge_ok_c, wait_last_c;
    logic capture_c, abort_c, rom_wr_c, shd_wr_c, elk_ok_c;
    logic lat_en_nxt, cpu_rdy_nxt, busy_nxt;
    logic unused_data_c;

    assign unused_data_c = ^cpu_data[6:4];

    // phi0 synchroniser, edge register and 1MHz slot tracker
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            phi0_sync <= '0;
            phi0_d    <= 1'b0;
            slot1m_q  <= 1'b0;
        end else begin
            phi0_sync <= {phi0_sync[SYNC_STAGES-2:0], bbc_phi0};
            phi0_d    <= phi0_sync[SYNC_STAGES-1];
            if (phi0_rise_c) slot1m_q <= ~slot1m_q;
        end
    end

    assign phi0_rise_c = phi0_sync[SYNC_STAGES-1] & ~phi0_d;
    assign edge_ok_c   = phi0_rise_c & (~req_fe4x | slot1m_q);
    assign wait_last_c = (wait_cnt >= WAIT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (host_req) state_nxt = S_SYNC;
            S_SYNC: begin
                if (edge_ok_c)        state_nxt = S_HOLD;
                else if (wait_last_c) state_nxt = S_DONE;
            end
            S_HOLD: if (hold_cnt == '0) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM output/control decode
    always_comb begin
        capture_c   = 1'b0;
        abort_c     = 1'b0;
        rom_wr_c    = 1'b0;
        shd_wr_c    = 1'b0;
        elk_ok_c    = req_lo[3] | (req_lo[3:2] == 2'b00);
        lat_en_nxt  = (state_nxt == S_HOLD);
        cpu_rdy_nxt = (state_nxt == S_DONE);
        busy_nxt    = (state_nxt != S_IDLE);
        case (state)
            S_IDLE: capture_c = host_req;
            S_SYNC: abort_c   = ~edge_ok_c & wait_last_c;
            S_DONE: begin
                rom_wr_c = ~req_abort & ~req_rnw & req_rom & ((req_j != J_ELK) | elk_ok_c);
                shd_wr_c = ~req_abort & ~req_rnw & req_shd & (req_j == J_BPLUS);
            end
            default: ;
        endcase
    end

    // Request capture, counters, registered outputs and shadow registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            req_rnw     <= 1'b0;
            req_rom     <= 1'b0;
            req_shd     <= 1'b0;
            req_fe4x    <= 1'b0;
            req_j       <= 2'b00;
            req_lo      <= 4'h0;
            req_b7      <= 1'b0;
            req_abort   <= 1'b0;
            wait_cnt    <= '0;
            hold_cnt    <= '0;
            lat_en      <= 1'b0;
            cpu_rdy     <= 1'b0;
            host_busy   <= 1'b0;
            timeout_err <= 1'b0;
            rom_bank_q  <= 4'h0;
            shadow_en_q <= 1'b0;
        end else begin
            lat_en    <= lat_en_nxt;
            cpu_rdy   <= cpu_rdy_nxt;
            host_busy <= busy_nxt;
            if (capture_c) begin
                req_rnw   <= cpu_rnw;
                req_rom   <= dec_rom_reg;
                req_shd   <= dec_shadow_reg;
                req_fe4x  <= dec_fe4x;
                req_j     <= j;
                req_lo    <= cpu_data[3:0];
                req_b7    <= cpu_data[7];
                req_abort <= 1'b0;
                wait_cnt  <= '0;
            end else if (state == S_SYNC && !edge_ok_c && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (abort_c) begin
                req_abort   <= 1'b1;
                timeout_err <= 1'b1;
            end
            if (state == S_SYNC && edge_ok_c)
                hold_cnt <= HOLD_LOAD;
            else if (state == S_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            if (rom_wr_c) rom_bank_q  <= req_lo;
            if (shd_wr_c) shadow_en_q <= req_b7;
        end
    end

endmodule

// File: tb/tb_bbc_host_cycle_ctrl.sv
// Directed bench for bbc_host_cycle_ctrl: phi0 at clk/8, per-feature test tasks.
module tb_bbc_host_cycle_ctrl;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       bbc_phi0 = 1'b0;
    logic [1:0] j = 2'b00;
    logic       host_req = 1'b0;
    logic       cpu_rnw = 1'b1;
    logic [7:0] cpu_data = 8'h00;
    logic       dec_rom_reg = 1'b0;
    logic       dec_shadow_reg = 1'b0;
    logic       dec_fe4x = 1'b0;
    logic       lat_en, cpu_rdy, host_busy, timeout_err, shadow_en_q;
    logic [3:0] rom_bank_q;

    logic phi0_run = 1'b1;
    int   phi_rises = 0;
    int   phi_base = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    bbc_host_cycle_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(4), .TIMEOUT(63)) dut (
        .clk(clk), .resetb(resetb), .bbc_phi0(bbc_phi0), .j(j),
        .host_req(host_req), .cpu_rnw(cpu_rnw), .cpu_data(cpu_data),
        .dec_rom_reg(dec_rom_reg), .dec_shadow_reg(dec_shadow_reg), .dec_fe4x(dec_fe4x),
        .lat_en(lat_en), .cpu_rdy(cpu_rdy), .host_busy(host_busy),
        .timeout_err(timeout_err), .rom_bank_q(rom_bank_q), .shadow_en_q(shadow_en_q)
    );

    always #5 clk = ~clk;

    // phi0 = clk/8, offset from both clk edges; forced low when stopped
    initial begin
        #2;
        forever begin
            #40;
            if (phi0_run) bbc_phi0 = ~bbc_phi0;
            else          bbc_phi0 = 1'b0;
        end
    end

    always @(posedge bbc_phi0) phi_rises++;

    // Runs one host access; reports lat_en width, cpu_rdy pulses, clk edges to cpu_rdy
    // and the phi0 rise index (relative to phi_base) at which lat_en first rose.
    task automatic do_xfer(input logic rnw, input logic [7:0] data, input logic rom,
                           input logic shd, input logic fe4x,
                           output int lat_cyc, output int rdy_cnt, output int to_rdy,
                           output int lat_rise);
        lat_cyc = 0; rdy_cnt = 0; to_rdy = -1; lat_rise = -1;
        @(negedge clk);
        host_req = 1'b1; cpu_rnw = rnw; cpu_data = data;
        dec_rom_reg = rom; dec_shadow_reg = shd; dec_fe4x = fe4x;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (lat_en) begin
                if (lat_rise < 0) lat_rise = phi_rises - phi_base;
                lat_cyc++;
            end
            if (cpu_rdy) begin
                rdy_cnt++;
                to_rdy = i;
                break;
            end
        end
        host_req = 1'b0; dec_rom_reg = 1'b0; dec_shadow_reg = 1'b0; dec_fe4x = 1'b0;
        if (to_rdy < 0) begin
            n_checks++; n_fail++;
            $display("FAIL xfer_bound: cpu_rdy never seen within 400 clks");
        end
        repeat (3) begin
            @(negedge clk);
            if (lat_en)  lat_cyc++;
            if (cpu_rdy) rdy_cnt++;
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({lat_en, cpu_rdy, host_busy, timeout_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0000", {lat_en, cpu_rdy, host_busy, timeout_err});
        end
        n_checks++;
        if (rom_bank_q !== 4'h0) begin n_fail++; $display("FAIL reset_rom: got %h want 0", rom_bank_q); end
        n_checks++;
        if (shadow_en_q !== 1'b0) begin n_fail++; $display("FAIL reset_shadow: got %b want 0", shadow_en_q); end
        resetb = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_beeb_rom_write();
        int l, r, t, lr;
        j = 2'b00;
        do_xfer(1'b0, 8'h0C, 1'b1, 1'b0, 1'b0, l, r, t, lr);
        n_checks++; if (l !== 5) begin n_fail++; $display("FAIL beeb_lat_width: got %0d want 5", l); end
        n_checks++; if (r !== 1) begin n_fail++; $display("FAIL beeb_rdy_pulses: got %0d want 1", r); end
        n_checks++; if (rom_bank_q !== 4'hC) begin n_fail++; $display("FAIL beeb_rom: got %h want c", rom_bank_q); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL beeb_timeout: got %b want 0", timeout_err); end
        n_checks++; if (host_busy !== 1'b0) begin n_fail++; $display("FAIL beeb_busy_after: got %b want 0", host_busy); end
    endtask

    task automatic test_fe4x_slot();
        int l, r, t, lr;
        bit seen;
        phi0_run = 1'b0;
        #100;
        @(negedge clk); resetb = 1'b0;
        repeat (2) @(negedge clk); resetb = 1'b1;
        repeat (2) @(negedge clk);
        phi_base = phi_rises;
        phi0_run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (phi_rises - phi_base == 2) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL fe4x_phi0_start: rises %0d want 2", phi_rises - phi_base); end
        repeat (3) @(negedge clk);
        j = 2'b00;
        do_xfer(1'b1, 8'h05, 1'b1, 1'b0, 1'b1, l, r, t, lr);
        n_checks++; if (lr !== 4) begin n_fail++; $display("FAIL fe4x_edge: lat_en on phi0 rise %0d want 4", lr); end
        n_checks++; if (l !== 5) begin n_fail++; $display("FAIL fe4x_lat_width: got %0d want 5", l); end
        n_checks++; if (r !== 1) begin n_fail++; $display("FAIL fe4x_rdy_pulses: got %0d want 1", r); end
        n_checks++; if (rom_bank_q !== 4'h0) begin n_fail++; $display("FAIL fe4x_read_rom: got %h want 0", rom_bank_q); end
    endtask

    task automatic test_shadow();
        int l, r, t, lr;
        j = 2'b01;
        do_xfer(1'b0, 8'h80, 1'b0, 1'b1, 1'b0, l, r, t, lr);
        n_checks++; if (shadow_en_q !== 1'b1) begin n_fail++; $display("FAIL bplus_shadow_set: got %b want 1", shadow_en_q); end
        do_xfer(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, l, r, t, lr);
        n_checks++; if (shadow_en_q !== 1'b0) begin n_fail++; $display("FAIL bplus_shadow_clr: got %b want 0", shadow_en_q); end
        j = 2'b00;
        do_xfer(1'b0, 8'h80, 1'b0, 1'b1, 1'b0, l, r, t, lr);
        n_checks++; if (shadow_en_q !== 1'b0) begin n_fail++; $display("FAIL beeb_shadow_ignored: got %b want 0", shadow_en_q); end
    endtask

    task automatic test_elk_rom();
        int l, r, t, lr;
        j = 2'b10;
        do_xfer(1'b0, 8'h08, 1'b1, 1'b0, 1'b0, l, r, t, lr);
        n_checks++; if (rom_bank_q !== 4'h8) begin n_fail++; $display("FAIL elk_bank8: got %h want 8", rom_bank_q); end
        do_xfer(1'b0, 8'h04, 1'b1, 1'b0, 1'b0, l, r, t, lr);
        n_checks++; if (rom_bank_q !== 4'h8) begin n_fail++; $display("FAIL elk_bank4_ignored: got %h want 8", rom_bank_q); end
        do_xfer(1'b0, 8'h02, 1'b1, 1'b0, 1'b0, l, r, t, lr);
        n_checks++; if (rom_bank_q !== 4'h2) begin n_fail++; $display("FAIL elk_bank2: got %h want 2", rom_bank_q); end
    endtask

    task automatic test_timeout();
        int l, r, t, lr;
        j = 2'b00;
        phi0_run = 1'b0;
        #100;
        do_xfer(1'b0, 8'h03, 1'b1, 1'b0, 1'b0, l, r, t, lr);
        n_checks++; if (t !== 64) begin n_fail++; $display("FAIL timeout_latency: got %0d clks want 64", t); end
        n_checks++; if (r !== 1) begin n_fail++; $display("FAIL timeout_rdy_pulses: got %0d want 1", r); end
        n_checks++; if (l !== 0) begin n_fail++; $display("FAIL timeout_lat_en: got %0d high clks want 0", l); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b want 1", timeout_err); end
        n_checks++; if (rom_bank_q !== 4'h2) begin n_fail++; $display("FAIL timeout_rom_kept: got %h want 2", rom_bank_q); end
        phi0_run = 1'b1;
        #100;
    endtask

    task automatic test_reset_mid_hold();
        int l, r, t, lr;
        bit seen;
        j = 2'b00;
        @(negedge clk);
        host_req = 1'b1; cpu_rnw = 1'b0; cpu_data = 8'h0A; dec_rom_reg = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (lat_en) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rst_hold_entry: lat_en %b want 1", lat_en); end
        @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        n_checks++; if (lat_en !== 1'b0) begin n_fail++; $display("FAIL rst_lat_en: got %b want 0", lat_en); end
        n_checks++;
        if ({cpu_rdy, host_busy, timeout_err} !== 3'b000) begin
            n_fail++; $display("FAIL rst_ctl: got %b want 000", {cpu_rdy, host_busy, timeout_err});
        end
        n_checks++; if (rom_bank_q !== 4'h0) begin n_fail++; $display("FAIL rst_rom: got %h want 0", rom_bank_q); end
        host_req = 1'b0; dec_rom_reg = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (host_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy %b want 0", host_busy); end
        do_xfer(1'b0, 8'h07, 1'b1, 1'b0, 1'b0, l, r, t, lr);
        n_checks++; if (l !== 5) begin n_fail++; $display("FAIL post_rst_lat_width: got %0d want 5", l); end
        n_checks++; if (r !== 1) begin n_fail++; $display("FAIL post_rst_rdy: got %0d want 1", r); end
        n_checks++; if (rom_bank_q !== 4'h7) begin n_fail++; $display("FAIL post_rst_rom: got %h want 7", rom_bank_q); end
    endtask

    initial begin
        test_reset();
        test_beeb_rom_write();
        test_fe4x_slot();
        test_shadow();
        test_elk_rom();
        test_timeout();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bbc_host_cycle_ctrl.md
Name: bbc_host_cycle_ctrl

Overview:
- Responder-side sequencer for CPU accesses that must go out to the BBC/Elk/B+/Master host bus.
- Consumes the decode flags produced by the address decoder (dec_rom_reg, dec_shadow_reg, dec_fe4x) plus a host-access request.
- Aligns each access to the host 2MHz phi0 phase, or to the 1MHz slot for FE4x/FC/FD, and holds the fast CPU in wait meanwhile.
- Drives lat_en back to the address decoder and keeps local shadow copies of the paged-ROM select and B+ shadow-RAM registers.

Parameters:
- SYNC_STAGES, 2, flops in the phi0 synchroniser (min 2).
- HOLD_CYCLES, 4, clk cycles lat_en stays high after the phi0 rising edge that starts the host cycle (range 1..15).
- TIMEOUT, 63, clk cycles to wait for a usable phi0 edge before aborting (6-bit counter).

Ports:
- clk  in  1  fast CPU-side clock, at least 8x phi0.
- resetb  in  1  asynchronous active-low reset.
- bbc_phi0  in  1  host 2MHz clock, asynchronous to clk.
- j  in  2  mode jumpers: 00 Beeb, 01 B+, 10 Elk, 11 Master.
- host_req  in  1  CPU presents a valid address needing a host cycle; held until cpu_rdy.
- cpu_rnw  in  1  1 = read, 0 = write; sampled with host_req.
- cpu_data  in  8  write data; valid while host_req is high.
- dec_rom_reg  in  1  address hits the paged-ROM select register.
- dec_shadow_reg  in  1  address hits the B+ shadow register (already mode-gated).
- dec_fe4x  in  1  access needs the 1MHz slot.
- lat_en  out  1  address latch enable to the decoder.
- cpu_rdy  out  1  one-cycle completion pulse to the CPU wait logic.
- host_busy  out  1  high from request acceptance until cpu_rdy.
- timeout_err  out  1  sticky; set on abort, cleared by reset only.
- rom_bank_q  out  4  shadow copy of the paged-ROM select register.
- shadow_en_q  out  1  B+ shadow RAM enable.

Behaviour:
- Reset (async, resetb low): all state and outputs 0, FSM in IDLE, slot1m_q = 0.
- Synchroniser:
  - bbc_phi0 passes through SYNC_STAGES flops, then one edge register.
  - phi0_rise is a 1-clk pulse when the synced value goes 0 to 1.
  - slot1m_q toggles on every phi0_rise.
- FSM states: IDLE, SYNC, HOLD, DONE.
- IDLE:
  - When host_req = 1: capture cpu_rnw, cpu_data, the three dec flags and j into request regs.
  - Clear wait counter, set host_busy, go to SYNC.
- SYNC: wait for a phi0_rise.
  - If captured dec_fe4x = 1, that edge must also have slot1m_q = 1 (the pre-toggle value).
  - On a qualifying edge: lat_en = 1, load hold counter with HOLD_CYCLES, go to HOLD.
  - Otherwise increment the wait counter. When it reaches TIMEOUT: set timeout_err, go to DONE with no register update.
- HOLD:
  - lat_en stays 1 and the hold counter decrements.
  - At 0, deassert lat_en and go to DONE.
  - A full cycle keeps lat_en high for exactly HOLD_CYCLES+1 clocks.
- DONE:
  - cpu_rdy = 1 for exactly one clk and host_busy clears on the next edge. Return to IDLE.
  - Register update happens on this cycle only, for a non-aborted write (cpu_rnw = 0):
    - dec_rom_reg: rom_bank_q <= cpu_data[3:0]. In Elk mode (j = 10) the update happens only if cpu_data[3] = 1 or cpu_data[3:2] = 00; otherwise it is ignored.
    - dec_shadow_reg with j = 01: shadow_en_q <= cpu_data[7].
    - Both dec flags set: both updates apply.
  - Reads never modify the registers.
- Back-to-back requests: host_req still high in the cycle after DONE starts a new request; minimum gap is one IDLE cycle.
- host_req dropping mid-cycle: the cycle still completes; the CPU owns the protocol.
- Reset mid-cycle: lat_en and cpu_rdy drop immediately; registers return to 0.
- Counter widths:
  - Wait counter is 6 bits and saturates at TIMEOUT.
  - Hold counter is 4 bits.

Test Plan:
- Reset with phi0 running: all outputs 0. Beeb mode, write 0x0C with dec_rom_reg, phi0 at clk/8 -> lat_en high 5 clks after the first synced rise, one cpu_rdy pulse, rom_bank_q = 0xC, timeout_err = 0.
- dec_fe4x read issued just after a slot1m_q = 1 edge -> the next edge (slot 0) is skipped and lat_en rises on the following one (about 16 clks later); no register change.
- B+ mode, write 0x80 with dec_shadow_reg -> shadow_en_q = 1. Then write 0x00 -> 0. Same writes in Beeb mode -> shadow_en_q stays 0.
- Elk mode, dec_rom_reg writes 0x08 -> bank 8; then 0x04 -> ignored (stays 8); then 0x02 -> bank 2.
- phi0 held low, request issued -> after 63 clks cpu_rdy pulses, timeout_err = 1, rom_bank_q unchanged, lat_en never high.
- resetb asserted during HOLD -> lat_en = 0 asynchronously and FSM in IDLE. After release, a new request completes normally.
